// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants for the compress/decompress datapath
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_NC  = 8;
    localparam int KYBER_CW  = 12;

    localparam logic [3:0] D_W1  = 4'd1;
    localparam logic [3:0] D_W4  = 4'd4;
    localparam logic [3:0] D_W10 = 4'd10;

    // Reciprocal shift for the constant divider; exact for dividends below 2^23
    localparam int DIV_SHIFT = 35;

endpackage

// File: rtl/kyber_coef_round.sv
// rtl/kyber_coef_round.sv - per-coefficient compress and decompress rounding
module kyber_coef_round
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic [3:0]          d,
    input  logic [KYBER_CW-1:0] x,
    input  logic [9:0]          y,
    output logic [9:0]          c,
    output logic [KYBER_CW-1:0] z
);

    localparam logic [23:0] DIV_M =
        24'(((64'd1 << DIV_SHIFT) + 64'(Q) - 64'd1) / 64'(Q));

    logic [22:0] num;
    logic [46:0] prod;
    logic [9:0]  mask;
    logic [22:0] half;
    logic [22:0] dsum;

    always_comb begin
        num  = (23'(x) << d) + 23'((Q - 1) / 2);
        // floor(num / Q) via ceil(2^35 / Q) reciprocal
        prod = 47'(num) * 47'(DIV_M);
        mask = ~(10'h3ff << d);
        c    = 10'(prod >> DIV_SHIFT) & mask;
        half = (23'd1 << d) >> 1;
        dsum = 23'(y) * 23'(Q) + half;
        z    = 12'(dsum >> d);
    end

endmodule

// File: rtl/kyber_comp_decomp.sv
// rtl/kyber_comp_decomp.sv - registered 8-lane Kyber compress/decompress for d = 1, 4, 10
module kyber_comp_decomp
    import kyber_pkg::*;
#(
    parameter int Q  = KYBER_Q,
    parameter int NC = KYBER_NC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             d,
    input  logic [NC*KYBER_CW-1:0] comp_in,
    output logic [NC-1:0]          comp_out_d1,
    output logic [4*NC-1:0]        comp_out_d4,
    output logic [10*NC-1:0]       comp_out_d10,
    input  logic [NC-1:0]          decomp_in_d1,
    input  logic [4*NC-1:0]        decomp_in_d4,
    input  logic [10*NC-1:0]       decomp_in_d10,
    output logic [NC*KYBER_CW-1:0] decomp_out
);

    logic [NC-1:0]          c1_w;
    logic [4*NC-1:0]        c4_w;
    logic [10*NC-1:0]       c10_w;
    logic [NC*KYBER_CW-1:0] z_w;

    for (genvar i = 0; i < NC; i++) begin : g_coef
        logic [9:0] y_sel;
        logic [9:0] c_i;

        always_comb begin
            case (d)
                D_W1:    y_sel = 10'(decomp_in_d1[i]);
                D_W4:    y_sel = 10'(decomp_in_d4[4*i +: 4]);
                default: y_sel = decomp_in_d10[10*i +: 10];
            endcase
        end

        kyber_coef_round #(.Q(Q)) u_round (
            .d (d),
            .x (comp_in[KYBER_CW*i +: KYBER_CW]),
            .y (y_sel),
            .c (c_i),
            .z (z_w[KYBER_CW*i +: KYBER_CW])
        );

        assign c1_w[i]         = c_i[0];
        assign c4_w[4*i +: 4]  = c_i[3:0];
        assign c10_w[10*i +: 10] = c_i;
    end

    // Only the width matching d loads; illegal d codes leave every output untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_out_d1  <= '0;
            comp_out_d4  <= '0;
            comp_out_d10 <= '0;
            decomp_out   <= '0;
        end else begin
            case (d)
                D_W1: begin
                    comp_out_d1 <= c1_w;
                    decomp_out  <= z_w;
                end
                D_W4: begin
                    comp_out_d4 <= c4_w;
                    decomp_out  <= z_w;
                end
                D_W10: begin
                    comp_out_d10 <= c10_w;
                    decomp_out   <= z_w;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_comp_decomp.sv
// tb/tb_kyber_comp_decomp.sv - randomized and directed checks of kyber_comp_decomp
module tb_kyber_comp_decomp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  d = 4'd0;
    logic [95:0] comp_in = '0;
    logic [7:0]  comp_out_d1;
    logic [31:0] comp_out_d4;
    logic [79:0] comp_out_d10;
    logic [7:0]  decomp_in_d1 = '0;
    logic [31:0] decomp_in_d4 = '0;
    logic [79:0] decomp_in_d10 = '0;
    logic [95:0] decomp_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  e1  = '0;
    logic [31:0] e4  = '0;
    logic [79:0] e10 = '0;
    logic [95:0] edc = '0;

    logic [7:0]  save1;
    logic [31:0] save4;
    logic [95:0] cw;
    logic [7:0]  r1;
    logic [31:0] r4;
    logic [79:0] r10;
    int          xs29 [8] = '{0, 832, 833, 1664, 2496, 2497, 3328, 1};
    int          xs30 [8] = '{3328, 1, 2, 1665, 0, 4095, 3329, 100};

    kyber_comp_decomp dut (
        .clk           (clk),
        .rst           (rst),
        .d             (d),
        .comp_in       (comp_in),
        .comp_out_d1   (comp_out_d1),
        .comp_out_d4   (comp_out_d4),
        .comp_out_d10  (comp_out_d10),
        .decomp_in_d1  (decomp_in_d1),
        .decomp_in_d4  (decomp_in_d4),
        .decomp_in_d10 (decomp_in_d10),
        .decomp_out    (decomp_out)
    );

    always #5 clk = ~clk;

    function automatic int m_comp(int x, int dw);
        return ((x * (1 << dw)) + 1664) / 3329 % (1 << dw);
    endfunction

    function automatic int m_decomp(int y, int dw);
        return (y * 3329 + (1 << (dw - 1))) / (1 << dw);
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".d1"},  96'(comp_out_d1),  96'(e1));
        chk({tag, ".d4"},  96'(comp_out_d4),  96'(e4));
        chk({tag, ".d10"}, 96'(comp_out_d10), 96'(e10));
        chk({tag, ".dec"}, decomp_out, edc);
    endtask

    task automatic model_clear();
        e1 = '0; e4 = '0; e10 = '0; edc = '0;
    endtask

    task automatic step(input string tag, input logic [3:0] dd, input logic [95:0] cin,
                        input logic [7:0] y1, input logic [31:0] y4, input logic [79:0] y10);
        int c;
        int y;
        d = dd; comp_in = cin;
        decomp_in_d1 = y1; decomp_in_d4 = y4; decomp_in_d10 = y10;
        @(posedge clk);
        #1;
        if (dd == 4'd1 || dd == 4'd4 || dd == 4'd10) begin
            for (int i = 0; i < 8; i++) begin
                c = m_comp(int'(cin[12*i +: 12]), int'(dd));
                if (dd == 4'd1) begin
                    e1[i] = c[0];
                    y = int'(y1[i]);
                end else if (dd == 4'd4) begin
                    e4[4*i +: 4] = 4'(c);
                    y = int'(y4[4*i +: 4]);
                end else begin
                    e10[10*i +: 10] = 10'(c);
                    y = int'(y10[10*i +: 10]);
                end
                edc[12*i +: 12] = 12'(m_decomp(y, int'(dd)));
            end
        end
        chk_all(tag);
    endtask

    task automatic rand_word();
        for (int i = 0; i < 8; i++) cw[12*i +: 12] = 12'($urandom_range(0, 4095));
        r1 = 8'($urandom); r4 = $urandom; r10 = {16'($urandom), $urandom, $urandom};
    endtask

    initial begin
        // Reset held across edges with live inputs
        rand_word();
        d = 4'd10; comp_in = cw;
        decomp_in_d1 = r1; decomp_in_d4 = r4; decomp_in_d10 = r10;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold");
        rst = 1'b0;

        // Compress d=1 rounding boundaries
        for (int i = 0; i < 8; i++) cw[12*i +: 12] = 12'(xs29[i]);
        step("d1_bound", 4'd1, cw, 8'h00, 32'h0, 80'h0);
        chk("d1_bound.const", 96'(comp_out_d1), 96'(8'b0001_1100));

        // Compress d=10 wrap and rounding; narrower outputs hold
        save1 = e1; save4 = e4;
        for (int i = 0; i < 8; i++) cw[12*i +: 12] = 12'(xs30[i]);
        step("d10_wrap", 4'd10, cw, 8'hff, 32'hffff_ffff, 80'h0);
        chk("d10_wrap.c0", 96'(comp_out_d10[9:0]),   96'd0);
        chk("d10_wrap.c1", 96'(comp_out_d10[19:10]), 96'd0);
        chk("d10_wrap.c2", 96'(comp_out_d10[29:20]), 96'd1);
        chk("d10_wrap.c3", 96'(comp_out_d10[39:30]), 96'd512);
        chk("d10_wrap.d1_held", 96'(comp_out_d1), 96'(save1));
        chk("d10_wrap.d4_held", 96'(comp_out_d4), 96'(save4));

        // Decompress, all three widths
        step("dec_d1", 4'd1, '0, 8'b0000_0001, 32'h0, 80'h0);
        chk("dec_d1.y1", 96'(decomp_out[11:0]),  96'd1665);
        chk("dec_d1.y0", 96'(decomp_out[23:12]), 96'd0);
        step("dec_d4", 4'd4, '0, 8'h0, 32'h0000_001f, 80'h0);
        chk("dec_d4.y15", 96'(decomp_out[11:0]),  96'd3121);
        chk("dec_d4.y1",  96'(decomp_out[23:12]), 96'd208);
        chk("dec_d4.y0",  96'(decomp_out[35:24]), 96'd0);
        r10 = '0; r10[9:0] = 10'd1023; r10[19:10] = 10'd1;
        step("dec_d10", 4'd10, '0, 8'h0, 32'h0, r10);
        chk("dec_d10.y1023", 96'(decomp_out[11:0]),  96'd3326);
        chk("dec_d10.y1",    96'(decomp_out[23:12]), 96'd3);
        chk("dec_d10.y0",    96'(decomp_out[35:24]), 96'd0);

        // Back-to-back width switching
        rand_word(); step("switch_10", 4'd10, cw, r1, r4, r10);
        rand_word(); step("switch_4",  4'd4,  cw, r1, r4, r10);
        rand_word(); step("switch_1",  4'd1,  cw, r1, r4, r10);

        // Illegal d holds everything
        rand_word(); step("illegal_d7", 4'd7, cw | 96'h1, r1 | 8'h1, r4 | 32'h1, r10 | 80'h1);

        // Random traffic, including occasional illegal codes
        for (int n = 0; n < 40; n++) begin
            int pick;
            logic [3:0] dd;
            rand_word();
            pick = int'($urandom_range(0, 7));
            dd = (pick < 2) ? 4'd1 : (pick < 4) ? 4'd4 : (pick < 7) ? 4'd10 : 4'($urandom);
            step($sformatf("rand%0d", n), dd, cw, r1, r4, r10);
        end

        // Mid-stream asynchronous reset
        rand_word();
        d = 4'd4; comp_in = cw;
        decomp_in_d1 = r1; decomp_in_d4 = r4 | 32'h1; decomp_in_d10 = r10;
        rst = 1'b1;
        #1;
        model_clear();
        chk_all("rst_async");
        @(posedge clk);
        #1;
        chk_all("rst_held");
        rst = 1'b0;
        rand_word(); step("rst_resume", 4'd10, cw, r1, r4, r10);
        rand_word(); step("rst_resume2", 4'd1, cw, r1, r4, r10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
